// File: rtl/exec_controller.sv
// Execution sequencer for the single-cycle CPU: produces the clock-enable that
// retires instructions, handling free-run, single-step, IN stalls and HLT.
module exec_controller #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Run_Mode,
   input  logic             Enter_Btn,
   input  logic             HLT,
   input  logic             InReq,
   output logic             CPU_En,
   output logic             In_Latch,
   output logic [2:0]       State,
   output logic             Halted,
   output logic [CNT_W-1:0] Instr_Count
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      STEP_WAIT = 3'd1,
      WAIT_IN   = 3'd2,
      ISSUE     = 3'd3,
      HALTED    = 3'd4
   } state_t;

   state_t          state, nxt;
   logic [1:0]      sync;
   logic            db, db_q, press;
   logic [DW-1:0]   db_cnt;

   // Button path: two-flop synchronizer, then a level only moves after the
   // synchronized value has disagreed with it for DEBOUNCE_CYCLES samples.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sync   <= 2'b00;
         db     <= 1'b0;
         db_q   <= 1'b0;
         db_cnt <= '0;
      end else begin
         sync <= {sync[0], Enter_Btn};
         db_q <= db;
         if (sync[1] == db)
            db_cnt <= '0;
         else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            db     <= sync[1];
            db_cnt <= '0;
         end else
            db_cnt <= db_cnt + DW'(1);
      end
   end

   assign press = db & ~db_q;

   // CPU_En and In_Latch must act in the same cycle as the decode, so the
   // transition logic is combinational and only the state is registered.
   always_comb begin
      nxt      = state;
      CPU_En   = 1'b0;
      In_Latch = 1'b0;
      case (state)
         RUN: begin
            if (HLT)            nxt = HALTED;
            else if (InReq)     nxt = WAIT_IN;
            else if (!Run_Mode) nxt = STEP_WAIT;
            else                CPU_En = 1'b1;
         end
         STEP_WAIT: begin
            if (Run_Mode)       nxt = RUN;
            else if (press) begin
               if (HLT)         nxt = HALTED;
               else if (InReq)  nxt = WAIT_IN;
               else             nxt = ISSUE;
            end
         end
         WAIT_IN: begin
            if (press) begin
               In_Latch = 1'b1;
               nxt      = ISSUE;
            end
         end
         ISSUE: begin
            CPU_En = 1'b1;
            nxt    = RUN;
         end
         HALTED:  nxt = HALTED;
         default: nxt = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state       <= RUN;
         Halted      <= 1'b0;
         Instr_Count <= '0;
      end else begin
         state       <= nxt;
         Halted      <= (nxt == HALTED);
         Instr_Count <= Instr_Count + CNT_W'(CPU_En);
      end
   end

   assign State = state;

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: directed scenarios plus a randomized run checked
// against a behavioural model of the sequencer.
module tb_exec_controller;

   localparam int DB = 4;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          Reset = 1'b1;
   logic          Run_Mode = 1'b1;
   logic          Enter_Btn = 1'b0;
   logic          HLT = 1'b0;
   logic          InReq = 1'b0;
   logic          CPU_En, In_Latch, Halted;
   logic [2:0]    State;
   logic [CW-1:0] Instr_Count;

   int tests = 0;
   int fails = 0;

   exec_controller #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
      .CLK(CLK), .Reset(Reset), .Run_Mode(Run_Mode), .Enter_Btn(Enter_Btn),
      .HLT(HLT), .InReq(InReq), .CPU_En(CPU_En), .In_Latch(In_Latch),
      .State(State), .Halted(Halted), .Instr_Count(Instr_Count)
   );

   always #5 CLK = ~CLK;

   // Reference model. Button: a press is seen the cycle after the raw button
   // history (two samples late for synchronizing) shows DB consecutive samples
   // at the opposite level to the debounced one, going high.
   bit [DB:0]   m_hist;
   bit          m_db, m_press;
   int          m_st, m_nx;
   bit          m_en, m_lat;
   bit [CW-1:0] m_cnt;

   always_comb begin
      m_en  = 1'b0;
      m_lat = 1'b0;
      m_nx  = m_st;
      case (m_st)
         0: if (HLT) m_nx = 4; else if (InReq) m_nx = 2;
            else if (!Run_Mode) m_nx = 1; else m_en = 1'b1;
         1: if (Run_Mode) m_nx = 0;
            else if (m_press) m_nx = HLT ? 4 : (InReq ? 2 : 3);
         2: if (m_press) begin m_lat = 1'b1; m_nx = 3; end
         3: begin m_en = 1'b1; m_nx = 0; end
         default: m_nx = 4;
      endcase
   end

   always @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         m_hist  <= '0;
         m_db    <= 1'b0;
         m_press <= 1'b0;
         m_st    <= 0;
         m_cnt   <= '0;
      end else begin
         m_hist <= {m_hist[DB-1:0], Enter_Btn};
         if (m_hist[DB:1] == {DB{~m_db}}) begin
            m_db    <= ~m_db;
            m_press <= ~m_db;
         end else
            m_press <= 1'b0;
         m_st <= m_nx;
         if (m_en) m_cnt <= m_cnt + 1'b1;
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      #1 Reset = 1'b0;
      #1;
      tests++; if (State !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", State); end
      tests++; if (Halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %0b want 0", Halted); end
      tests++; if (Instr_Count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", Instr_Count); end
      tests++; if (CPU_En !== 1'b1) begin fails++; $display("FAIL reset_cpu_en: got %0b want 1", CPU_En); end
      tests++; if (In_Latch !== 1'b0) begin fails++; $display("FAIL reset_in_latch: got %0b want 0", In_Latch); end
      repeat (2) cyc();
      tests++; if (Instr_Count !== 4'd0) begin fails++; $display("FAIL reset_hold_count: got %0d want 0", Instr_Count); end
      Reset = 1'b1;
   endtask

   task automatic test_free_run();
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         if (CPU_En !== 1'b1 || State !== 3'd0) bad++;
         cyc();
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL free_run_en: got %0d bad cycles want 0", bad); end
      tests++; if (Instr_Count !== 4'd10) begin fails++; $display("FAIL free_run_count: got %0d want 10", Instr_Count); end
   endtask

   task automatic test_in_stall();
      int lat = 0;
      int at = -1;
      logic [CW-1:0] c0;
      InReq = 1'b1;
      @(negedge CLK);
      tests++; if (CPU_En !== 1'b0) begin fails++; $display("FAIL in_stall_en: got %0b want 0", CPU_En); end
      cyc();
      tests++; if (State !== 3'd2) begin fails++; $display("FAIL in_stall_state: got %0d want 2", State); end
      InReq = 1'b0;
      Enter_Btn = 1'b1;
      repeat (3) cyc();
      Enter_Btn = 1'b0;
      repeat (12) begin
         @(negedge CLK);
         if (In_Latch) lat++;
         cyc();
      end
      tests++; if (lat != 0) begin fails++; $display("FAIL in_short_press: got %0d latches want 0", lat); end
      tests++; if (State !== 3'd2) begin fails++; $display("FAIL in_short_state: got %0d want 2", State); end
      lat = 0;
      c0 = Instr_Count;
      for (int i = 0; i < 16; i++) begin
         Enter_Btn = (i < 8);
         @(negedge CLK);
         if (In_Latch) begin lat++; if (at < 0) at = i; end
         if (i == 7) begin
            tests++; if (State !== 3'd3 || CPU_En !== 1'b1) begin
               fails++; $display("FAIL in_issue: got state %0d en %0b want 3/1", State, CPU_En); end
         end
         if (i == 8) begin
            tests++; if (State !== 3'd0 || Instr_Count !== c0 + 1'b1) begin
               fails++; $display("FAIL in_return: got state %0d count %0d want 0/%0d", State, Instr_Count, c0 + 1'b1); end
         end
         cyc();
      end
      tests++; if (lat != 1) begin fails++; $display("FAIL in_latch_count: got %0d want 1", lat); end
      tests++; if (at != 6) begin fails++; $display("FAIL in_latch_delay: got %0d want 6", at); end
   endtask

   task automatic test_single_step();
      int bad = 0;
      int pulses = 0;
      logic [CW-1:0] c0;
      Run_Mode = 1'b0;
      @(negedge CLK);
      tests++; if (CPU_En !== 1'b0) begin fails++; $display("FAIL step_enter_en: got %0b want 0", CPU_En); end
      cyc();
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (CPU_En !== 1'b0 || State !== 3'd1) bad++;
         cyc();
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL step_idle: got %0d bad cycles want 0", bad); end
      c0 = Instr_Count;
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 16; i++) begin
            Enter_Btn = (i < 8);
            @(negedge CLK);
            if (CPU_En) pulses++;
            cyc();
         end
      tests++; if (pulses != 3) begin fails++; $display("FAIL step_pulses: got %0d want 3", pulses); end
      tests++; if (Instr_Count !== c0 + 4'd3) begin fails++; $display("FAIL step_count: got %0d want %0d", Instr_Count, c0 + 4'd3); end
      tests++; if (State !== 3'd1) begin fails++; $display("FAIL step_state: got %0d want 1", State); end
   endtask

   task automatic test_bounce();
      int en = 0;
      logic [CW-1:0] c0 = Instr_Count;
      for (int i = 0; i < 40; i++) begin
         Enter_Btn = (i < 30) && (i % 2 == 0);
         @(negedge CLK);
         if (CPU_En) en++;
         cyc();
      end
      tests++; if (en != 0) begin fails++; $display("FAIL bounce_en: got %0d pulses want 0", en); end
      tests++; if (Instr_Count !== c0) begin fails++; $display("FAIL bounce_count: got %0d want %0d", Instr_Count, c0); end
   endtask

   task automatic test_halt();
      int bad = 0;
      logic [CW-1:0] c0;
      Run_Mode = 1'b1;
      cyc();
      HLT = 1'b1;
      @(negedge CLK);
      tests++; if (CPU_En !== 1'b0) begin fails++; $display("FAIL halt_en: got %0b want 0", CPU_En); end
      cyc();
      tests++; if (State !== 3'd4 || Halted !== 1'b1) begin
         fails++; $display("FAIL halt_state: got state %0d halted %0b want 4/1", State, Halted); end
      HLT = 1'b0;
      c0 = Instr_Count;
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 16; i++) begin
            Enter_Btn = (i < 8);
            if (i == 3) Run_Mode = ~Run_Mode;
            @(negedge CLK);
            if (State !== 3'd4 || Halted !== 1'b1 || CPU_En !== 1'b0) bad++;
            cyc();
         end
      tests++; if (bad != 0) begin fails++; $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
      tests++; if (Instr_Count !== c0) begin fails++; $display("FAIL halt_count: got %0d want %0d", Instr_Count, c0); end
      @(posedge CLK);
      #3 Reset = 1'b0;
      #1;
      tests++; if (State !== 3'd0 || Halted !== 1'b0 || Instr_Count !== 4'd0) begin
         fails++; $display("FAIL halt_reset: got state %0d halted %0b count %0d want 0/0/0", State, Halted, Instr_Count); end
      Run_Mode = 1'b1;
      cyc();
      Reset = 1'b1;
   endtask

   task automatic test_wrap();
      Reset = 1'b0;
      cyc();
      Reset = 1'b1;
      for (int i = 0; i < 17; i++) begin
         cyc();
         tests++; if (Instr_Count !== CW'(i + 1)) begin
            fails++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, Instr_Count, CW'(i + 1)); end
      end
   endtask

   task automatic test_random();
      int hold = 0;
      int halt_cyc = 0;
      Reset = 1'b0;
      cyc();
      Reset = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         if (hold == 0) begin
            Enter_Btn = 1'($urandom % 2);
            hold = $urandom_range(1, 12);
         end
         hold--;
         if ($urandom % 40 == 0) Run_Mode = ~Run_Mode;
         InReq = ($urandom % 6 == 0);
         HLT   = ($urandom % 80 == 0);
         if (m_st == 4) halt_cyc++;
         Reset = !(halt_cyc > 15);
         if (halt_cyc > 15) halt_cyc = 0;
         @(negedge CLK);
         tests++; if (CPU_En !== m_en) begin fails++; $display("FAIL rnd_en[%0d]: got %0b want %0b", n, CPU_En, m_en); end
         tests++; if (In_Latch !== m_lat) begin fails++; $display("FAIL rnd_latch[%0d]: got %0b want %0b", n, In_Latch, m_lat); end
         tests++; if (State !== 3'(m_st)) begin fails++; $display("FAIL rnd_state[%0d]: got %0d want %0d", n, State, m_st); end
         tests++; if (Halted !== (m_st == 4)) begin fails++; $display("FAIL rnd_halted[%0d]: got %0b want %0b", n, Halted, m_st == 4); end
         tests++; if (Instr_Count !== m_cnt) begin fails++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, Instr_Count, m_cnt); end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_in_stall();
      test_single_step();
      test_bounce();
      test_halt();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
